myip_adp_s_axil_slave: RTL and testbench

AXI4-Lite slave (responder) fronting the myip_adp_s register bank: four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC. It sits behind the AXI4-Lite master VIP in the block-design wrapper and answers its AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic. Write and read channels run independently, each with one transaction outstanding.

---
 rtl/myip_adp_s_pkg.sv | 34 +++
 rtl/myip_adp_s_regfile.sv | 40 ++++
 rtl/myip_adp_s_axil_slave.sv | 176 +++++++++++++++++
 tb/tb_myip_adp_s_axil_slave.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myip_adp_s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : myip_adp_s_pkg
// Description : Shared constants and types for the myip_adp_s AXI4-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
package myip_adp_s_pkg;

    localparam int NUM_REGS  = 4;
    localparam int ADDR_LSB  = 2;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    localparam logic [3:0] REG0_OFF = 4'h0;
    localparam logic [3:0] REG1_OFF = 4'h4;
    localparam logic [3:0] REG2_OFF = 4'h8;
    localparam logic [3:0] REG3_OFF = 4'hC;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/myip_adp_s_regfile.sv
`default_nettype none
// ============================================================================
// Module      : myip_adp_s_regfile
// Description : 4x32 register bank, byte-strobed write port, async read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module myip_adp_s_regfile
    import myip_adp_s_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wstrb_i,
    input  logic [REG_IDX_W-1:0] raddr_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    regs_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Reads see the pre-edge contents, so a same-edge write never leaks through.
    assign rdata_o = regs_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/myip_adp_s_axil_slave.sv
`default_nettype none
// ============================================================================
// Module      : myip_adp_s_axil_slave
// Description : AXI4-Lite slave for the myip_adp_s register bank.
//               Optional macro MYIP_ADP_S_SLVERR_EN: SLVERR on upper address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module myip_adp_s_axil_slave
    import myip_adp_s_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    wr_state_t   wr_state_q;
    rd_state_t   rd_state_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    resp_t       bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic        aw_held_q, w_held_q;
    logic [AW-1:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic          aw_have_d, w_have_d;
    logic [AW-1:0] awaddr_d;
    logic [31:0]   wdata_d;
    logic [3:0]    wstrb_d;
    logic          wr_bad, rd_bad;
    logic [31:0]   rf_rdata;

    assign aw_hs     = S_AXI_AWVALID & awready_q;
    assign w_hs      = S_AXI_WVALID & wready_q;
    assign ar_hs     = S_AXI_ARVALID & arready_q;
    assign aw_have_d = aw_held_q | aw_hs;
    assign w_have_d  = w_held_q | w_hs;
    assign awaddr_d  = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
    assign wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
    // Commit on the edge where the later of AW/W lands, using the live channel values.
    assign commit    = (wr_state_q == W_IDLE) & aw_have_d & w_have_d;

`ifdef MYIP_ADP_S_SLVERR_EN
    assign wr_bad = (awaddr_d >> 4) != '0;
    assign rd_bad = (S_AXI_ARADDR >> 4) != '0;
`else
    assign wr_bad = 1'b0;
    assign rd_bad = 1'b0;
`endif

    myip_adp_s_regfile u_regfile (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .we_i    (commit & ~wr_bad),
        .waddr_i (awaddr_d[ADDR_LSB +: REG_IDX_W]),
        .wdata_i (wdata_d),
        .wstrb_i (wstrb_d),
        .raddr_i (S_AXI_ARADDR[ADDR_LSB +: REG_IDX_W]),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (commit) begin
                        wr_state_q <= W_RESP;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_bad ? RESP_SLVERR : RESP_OKAY;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                    end else begin
                        aw_held_q  <= aw_have_d;
                        w_held_q   <= w_have_d;
                        awaddr_q   <= awaddr_d;
                        wdata_q    <= wdata_d;
                        wstrb_q    <= wstrb_d;
                        awready_q  <= ~aw_have_d;
                        wready_q   <= ~w_have_d;
                    end
                end
                W_RESP: begin
                    if (bvalid_q && S_AXI_BREADY) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= R_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_bad ? '0 : rf_rdata;
                        rresp_q    <= rd_bad ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && S_AXI_RREADY) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_d, S_AXI_ARADDR};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_myip_adp_s_axil_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_myip_adp_s_axil_slave
// Description : Directed self-checking bench for myip_adp_s_axil_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myip_adp_s_axil_slave;

`ifdef MYIP_ADP_S_SLVERR_EN
    localparam int AW = 5;
`else
    localparam int AW = 4;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0;
    logic [2:0]    S_AXI_AWPROT = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AW-1:0] S_AXI_ARADDR = '0;
    logic [2:0]    S_AXI_ARPROT = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    myip_adp_s_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    // Bus drivers: start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        logic aw_go, w_go, aw_done, w_done;
        int   n;
        S_AXI_AWADDR = a[AW-1:0];
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge ACLK);
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        total++;
        if (S_AXI_BVALID !== 1'b1) begin
            bad++;
            $display("FAIL wr_timeout addr=%h: bvalid=%b want 1", a, S_AXI_BVALID);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
        logic go, done;
        int   n;
        S_AXI_ARADDR  = a[AW-1:0];
        S_AXI_ARVALID = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge ACLK);
            go = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (go) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
            n++;
        end
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        total++;
        if (S_AXI_RVALID !== 1'b1) begin
            bad++;
            $display("FAIL rd_timeout addr=%h: rvalid=%b want 1", a, S_AXI_RVALID);
        end
        S_AXI_ARVALID = 1'b0;
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(posedge ACLK);
        #1;
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
            bad++;
            $display("FAIL rst_hs: got %b want 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
        end
        total++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
            bad++;
            $display("FAIL rst_data: got %h want 0", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA});
        end
        repeat (17) @(posedge ACLK);
        #5;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            bad++;
            $display("FAIL rst_release_ready: got %b want 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        for (int i = 0; i < 4; i++) begin
            do_read(8'(i * 4), d, r);
            total++;
            if (d !== 32'h0 || r !== 2'b00) begin
                bad++;
                $display("FAIL rst_read%0d: got %h/%b want 0/00", i, d, r);
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            do_write(8'(i * 4), 32'(i + 1), 4'hF, r);
            total++;
            if (r !== 2'b00) begin
                bad++;
                $display("FAIL basic_bresp%0d: got %b want 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(8'(i * 4), d, r);
            total++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                bad++;
                $display("FAIL basic_read%0d: got %h/%b want %h/00", i, d, r, 32'(i + 1));
            end
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads; 0: together.
    task automatic test_order(input int lead, input logic [31:0] val);
        logic [31:0] d;
        logic [1:0]  r;
        int          k;
        k = (lead < 0) ? -lead : lead;
        S_AXI_AWADDR = 'h4;
        S_AXI_WDATA  = val;
        S_AXI_WSTRB  = 4'hF;
        if (lead >= 0) S_AXI_WVALID  = 1'b1;
        if (lead <= 0) S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        if (lead != 0) begin
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            total++;
            if (S_AXI_BVALID !== 1'b0) begin
                bad++;
                $display("FAIL order%0d_early_bvalid: got %b want 0", lead, S_AXI_BVALID);
            end
            total++;
            if ({S_AXI_AWREADY, S_AXI_WREADY} !== ((lead > 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL order%0d_held_ready: got %b want %b", lead,
                         {S_AXI_AWREADY, S_AXI_WREADY}, (lead > 0) ? 2'b10 : 2'b01);
            end
            repeat (k - 1) begin
                @(posedge ACLK); #1;
            end
            if (lead > 0) S_AXI_AWVALID = 1'b1;
            else          S_AXI_WVALID  = 1'b1;
            @(posedge ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        total++;
        if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b1_00_00) begin
            bad++;
            $display("FAIL order%0d_resp: got %b want 10000", lead,
                     {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY});
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        total++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            bad++;
            $display("FAIL order%0d_single_b: got %b want 011", lead,
                     {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        end
        do_read(8'h4, d, r);
        total++;
        if (d !== val) begin
            bad++;
            $display("FAIL order%0d_data: got %h want %h", lead, d, val);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(8'h8, 32'hFFFF_FFFF, 4'hF, r);
        do_write(8'h8, 32'h1234_5678, 4'b0101, r);
        do_read(8'h8, d, r);
        total++;
        if (d !== 32'hFF34_FF78) begin
            bad++;
            $display("FAIL strobe: got %h want ff34ff78", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        S_AXI_AWADDR = 'h0;
        S_AXI_WDATA  = 32'hBEEF_0001;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_ARADDR = 'h0;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        total++;
        if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11 || S_AXI_RDATA !== 32'h1) begin
            bad++;
            $display("FAIL collision: got %b/%h want 11/00000001",
                     {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA);
        end
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        do_read(8'h0, d, r);
        total++;
        if (d !== 32'hBEEF_0001) begin
            bad++;
            $display("FAIL collision_after: got %h want beef0001", d);
        end
    endtask

    task automatic test_backpressure();
        S_AXI_AWADDR = 'hC;
        S_AXI_WDATA  = 32'hCAFE_F00D;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_ARADDR = 'h8;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 5'b11000
                || S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00 || S_AXI_RDATA !== 32'hFF34_FF78) begin
                bad++;
                $display("FAIL stall_c%0d: got %b %b %b %h want 11000 00 00 ff34ff78", c,
                         {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY},
                         S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
            end
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        total++;
        if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            bad++;
            $display("FAIL stall_release: got %b want 00", {S_AXI_BVALID, S_AXI_RVALID});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        S_AXI_WDATA  = 32'hDEAD_BEEF;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 'h0;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0
            || S_AXI_RDATA !== 32'h0) begin
            bad++;
            $display("FAIL midrst_clear: got %b/%h want 00000/0",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, S_AXI_RDATA);
        end
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
            bad++;
            $display("FAIL midrst_release: got %b want 11100",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        S_AXI_AWADDR  = 'h0;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        total++;
        if ({S_AXI_BVALID, S_AXI_WREADY} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_stale_w: got %b want 01", {S_AXI_BVALID, S_AXI_WREADY});
        end
        S_AXI_WDATA  = 32'h0000_0055;
        S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        total++;
        if (S_AXI_BVALID !== 1'b1) begin
            bad++;
            $display("FAIL midrst_bvalid: got %b want 1", S_AXI_BVALID);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        do_read(8'h0, d, r);
        total++;
        if (d !== 32'h55) begin
            bad++;
            $display("FAIL midrst_reg0: got %h want 00000055", d);
        end
        do_read(8'hC, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midrst_reg3: got %h want 00000000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        int          idx;
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        S_AXI_BREADY  = 1'b1;
        S_AXI_AWADDR  = 'h0;
        S_AXI_WDATA   = vals[0];
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge ACLK); #1;
            total++;
            if (S_AXI_BVALID !== 1'(e % 2)) begin
                bad++;
                $display("FAIL b2b_wr_e%0d: bvalid=%b want %b", e, S_AXI_BVALID, 1'(e % 2));
            end
            if (e == 1 || e == 3) begin
                idx = (e + 1) / 2;
                S_AXI_AWADDR = AW'(idx * 4);
                S_AXI_WDATA  = vals[idx];
            end
            if (e == 5) begin
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
            end
        end
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b1;
        S_AXI_ARADDR  = 'h0;
        S_AXI_ARVALID = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge ACLK); #1;
            total++;
            if (S_AXI_RVALID !== 1'(e % 2) || (e % 2 == 1 && S_AXI_RDATA !== vals[(e - 1) / 2])) begin
                bad++;
                $display("FAIL b2b_rd_e%0d: rvalid=%b rdata=%h want %b", e, S_AXI_RVALID,
                         S_AXI_RDATA, 1'(e % 2));
            end
            if (e == 1 || e == 3) S_AXI_ARADDR = AW'((e + 1) / 2 * 4);
            if (e == 5) S_AXI_ARVALID = 1'b0;
        end
        S_AXI_RREADY = 1'b0;
    endtask

`ifdef MYIP_ADP_S_SLVERR_EN
    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(8'h10, 32'h0000_0099, 4'hF, r);
        total++;
        if (r !== 2'b10) begin
            bad++;
            $display("FAIL slverr_bresp: got %b want 10", r);
        end
        do_read(8'h0, d, r);
        total++;
        if (d !== 32'h1111_1111 || r !== 2'b00) begin
            bad++;
            $display("FAIL slverr_reg0: got %h/%b want 11111111/00", d, r);
        end
        do_read(8'h10, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL slverr_read: got %h/%b want 0/10", d, r);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_rw();
        test_order(3, 32'hA000_0003);
        test_order(-3, 32'hA000_0005);
        test_order(0, 32'hA000_0007);
        test_strobe();
        test_collision();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef MYIP_ADP_S_SLVERR_EN
        test_slverr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
